// File: rtl/servo_pkg.sv
// Shared constants and arithmetic helpers for the multi-channel servo PWM block.
// Helpers work on a wide unsigned value type; callers size-cast in and out.
package servo_pkg;

   localparam int unsigned DEF_PERIOD_CYCLES = 32'd4000000;
   localparam int unsigned DEF_MIN_PULSE     = 32'd200000;
   localparam int unsigned DEF_MAX_PULSE     = 32'd400000;
   localparam int unsigned DEF_DEFAULT_PULSE = 32'd330000;
   localparam int unsigned DEF_STEP          = 32'd0;

   localparam int unsigned VAL_W = 32'd64;
   typedef logic [VAL_W-1:0] val_t;

   // Limit a requested pulse width to [lo, hi], unsigned compare.
   function automatic val_t clamp_pulse(input val_t value, input val_t lo, input val_t hi);
      val_t result;
      if (value < lo) begin
         result = lo;
      end else if (value > hi) begin
         result = hi;
      end else begin
         result = value;
      end
      return result;
   endfunction

   // Move cur toward tgt by at most step; step == 0 jumps straight to tgt.
   // Differences are formed only in the non-negative direction, so the
   // result never overshoots tgt and never wraps.
   function automatic val_t slew_step(input val_t cur, input val_t tgt, input val_t step);
      val_t result;
      if (step == {VAL_W{1'b0}}) begin
         result = tgt;
      end else if (tgt > cur) begin
         if ((tgt - cur) > step) begin
            result = cur + step;
         end else begin
            result = tgt;
         end
      end else begin
         if ((cur - tgt) > step) begin
            result = cur - step;
         end else begin
            result = tgt;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// One servo PWM channel: holds the written target, the width in use for the
// current frame, the frame-sampled enable and the registered output.
module servo_pwm_ch
   import servo_pkg::*;
#(
   parameter int unsigned CNT_W         = 32,
   parameter int unsigned DEFAULT_PULSE = DEF_DEFAULT_PULSE,
   parameter int unsigned STEP          = DEF_STEP
) (
   input  logic             clock_clk,
   input  logic             reset_low,
   input  logic [CNT_W-1:0] count,
   input  logic             boundary,
   input  logic             wr_strobe,
   input  logic [CNT_W-1:0] wr_value,
   input  logic             enable,
   output logic             pwm
);

   logic [CNT_W-1:0] target_r;
   logic [CNT_W-1:0] active_r;
   logic             enable_q_r;
   logic             pwm_r;
   logic [CNT_W-1:0] target_eff_s;
   logic [CNT_W-1:0] next_active_s;

   // Effective target and slew-limited next active width; a same-cycle write wins.
   always_comb begin
      target_eff_s  = target_r;
      next_active_s = active_r;
      if (wr_strobe) begin
         target_eff_s = wr_value;
      end else begin
         target_eff_s = target_r;
      end
      next_active_s = CNT_W'(slew_step(VAL_W'(active_r), VAL_W'(target_eff_s), VAL_W'(STEP)));
   end

   // Channel state: target on write, active/enable only at the frame boundary, output compare.
   always_ff @(posedge clock_clk or negedge reset_low) begin
      if (!reset_low) begin
         target_r   <= CNT_W'(DEFAULT_PULSE);
         active_r   <= CNT_W'(DEFAULT_PULSE);
         enable_q_r <= 1'b0;
         pwm_r      <= 1'b0;
      end else begin
         if (wr_strobe) begin
            target_r <= wr_value;
         end
         if (boundary) begin
            active_r   <= next_active_s;
            enable_q_r <= enable;
         end
         pwm_r <= enable_q_r && (count < active_r);
      end
   end

   assign pwm = pwm_r;

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator: shared frame counter, write decode with
// clamping, out-of-range write error flag, frame start strobe and one
// servo_pwm_ch per channel.
module servo_pwm_multi
   import servo_pkg::*;
#(
   parameter int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES,
   parameter int unsigned NUM_CH        = 4,
   parameter int unsigned CNT_W         = 32,
   parameter int unsigned MIN_PULSE     = DEF_MIN_PULSE,
   parameter int unsigned MAX_PULSE     = DEF_MAX_PULSE,
   parameter int unsigned DEFAULT_PULSE = DEF_DEFAULT_PULSE,
   parameter int unsigned STEP          = DEF_STEP,
   parameter int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clock_clk,
   input  logic              reset_low,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [CNT_W-1:0]  wr_pulse,
   output logic              wr_err,
   input  logic [NUM_CH-1:0] enable,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              frame_start,
   output logic              high,
   output logic              gnd
);

   logic [CNT_W-1:0]  count_r;
   logic              wr_ready_r;
   logic              wr_err_r;
   logic              frame_start_r;
   logic              boundary_s;
   logic              wr_fire_s;
   logic              ch_ok_s;
   logic [CNT_W-1:0]  clamped_s;
   logic [NUM_CH-1:0] wr_strobe_s;

   // Frame boundary detect, write acceptance, channel decode and clamped write data.
   always_comb begin
      boundary_s  = (count_r == CNT_W'(PERIOD_CYCLES - 32'd1));
      wr_fire_s   = wr_valid && wr_ready_r;
      ch_ok_s     = (32'(wr_ch) < NUM_CH);
      clamped_s   = CNT_W'(clamp_pulse(VAL_W'(wr_pulse), VAL_W'(MIN_PULSE), VAL_W'(MAX_PULSE)));
      wr_strobe_s = {NUM_CH{1'b0}};
      for (int c = 0; c < int'(NUM_CH); c++) begin
         if (wr_fire_s && (32'(wr_ch) == 32'(c))) begin
            wr_strobe_s[c] = 1'b1;
         end else begin
            wr_strobe_s[c] = 1'b0;
         end
      end
   end

   // Frame counter, write-ready, write-error pulse and frame-start strobe.
   always_ff @(posedge clock_clk or negedge reset_low) begin
      if (!reset_low) begin
         count_r       <= {CNT_W{1'b0}};
         wr_ready_r    <= 1'b0;
         wr_err_r      <= 1'b0;
         frame_start_r <= 1'b0;
      end else begin
         if (boundary_s) begin
            count_r <= {CNT_W{1'b0}};
         end else begin
            count_r <= count_r + CNT_W'(1);
         end
         wr_ready_r    <= 1'b1;
         wr_err_r      <= wr_fire_s && !ch_ok_s;
         // Lines up with the first high output cycle, which follows count == 0.
         frame_start_r <= (count_r == {CNT_W{1'b0}});
      end
   end

   for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
      servo_pwm_ch #(
         .CNT_W         (CNT_W),
         .DEFAULT_PULSE (DEFAULT_PULSE),
         .STEP          (STEP)
      ) u_ch (
         .clock_clk (clock_clk),
         .reset_low (reset_low),
         .count     (count_r),
         .boundary  (boundary_s),
         .wr_strobe (wr_strobe_s[g]),
         .wr_value  (clamped_s),
         .enable    (enable[g]),
         .pwm       (pwm_out[g])
      );
   end

   assign wr_ready    = wr_ready_r;
   assign wr_err      = wr_err_r;
   assign frame_start = frame_start_r;
   assign high        = 1'b1;
   assign gnd         = 1'b0;

endmodule
